muldiv_hilo_ctrl: RTL and testbench

- Sequences multi-cycle multiply/divide for the execute stage and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs an iterative 32-step restoring divider and a fixed-latency multiplier.
- Generates the arith_stall that freezes the EX pipeline register while an operation is in flight.
- Sits beside the ALU in EX; HI/LO outputs feed MFHI/MFLO selection.

---
 rtl/muldiv_hilo_ctrl.sv | 150 +++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner for the execute stage: fixed-latency multiplier, 32-step restoring
// divider, MTHI/MTLO writes and the EX stall that covers multi-cycle operations.
module muldiv_hilo_ctrl #(
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        arith_stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state, state_nx;
   logic [5:0]  cnt;
   logic [31:0] op_a, op_b, quo, rem;
   logic        mul_signed, neg_q, neg_r, div0;
   logic [63:0] pending;

   logic        accept, is_mul, is_div, sgn_op, ge;
   logic [31:0] abs_a, abs_b, diff, rem_nx, quo_nx, q_fix, r_fix;
   logic [32:0] trial;
   logic [63:0] ext_a, ext_b, product;

   assign accept = (state == IDLE) && op_valid && !flush;
   assign is_mul = (op == 3'd0) || (op == 3'd1);
   assign is_div = (op == 3'd2) || (op == 3'd3);
   assign sgn_op = (op == 3'd0) || (op == 3'd2);
   assign abs_a  = (sgn_op && src_a[31]) ? -src_a : src_a;
   assign abs_b  = (sgn_op && src_b[31]) ? -src_b : src_b;

   // Restoring step: op_b holds the divisor magnitude during DIV. The remainder is
   // always below the divisor, so the 32-bit difference is exact even if trial[32] is set.
   assign trial  = {rem, quo[31]};
   assign ge     = trial >= {1'b0, op_b};
   assign diff   = trial[31:0] - op_b;
   assign rem_nx = ge ? diff : trial[31:0];
   assign quo_nx = {quo[30:0], ge};
   assign q_fix  = div0 ? '1   : (neg_q ? -quo_nx : quo_nx);
   assign r_fix  = div0 ? op_a : (neg_r ? -rem_nx : rem_nx);

   assign ext_a   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
   assign ext_b   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
   assign product = ext_a * ext_b;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept && is_mul)      state_nx = MUL;
            else if (accept && is_div) state_nx = DIV;
         end
         MUL, DIV: begin
            if (flush)            state_nx = IDLE;
            else if (cnt == '0)   state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      arith_stall = 1'b0;
      if (rstn) begin
         case (state)
            IDLE:     arith_stall = accept && (is_mul || is_div);
            MUL, DIV: arith_stall = 1'b1;
            default:  arith_stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt        <= '0;
         op_a       <= '0;
         op_b       <= '0;
         quo        <= '0;
         rem        <= '0;
         mul_signed <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         div0       <= 1'b0;
         pending    <= '0;
         hi         <= '0;
         lo         <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         busy <= (state_nx == MUL) || (state_nx == DIV);
         done <= (state_nx == DONE);
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     op_a       <= src_a;
                     op_b       <= src_b;
                     mul_signed <= sgn_op;
                     cnt        <= 6'(MUL_CYCLES - 1);
                  end else if (is_div) begin
                     op_a  <= src_a;
                     op_b  <= abs_b;
                     quo   <= abs_a;
                     rem   <= '0;
                     neg_q <= sgn_op && (src_a[31] ^ src_b[31]);
                     neg_r <= sgn_op && src_a[31];
                     div0  <= (src_b == '0);
                     cnt   <= 6'd31;
                  end else if (op == 3'd4) begin
                     hi <= src_a;
                  end else if (op == 3'd5) begin
                     lo <= src_a;
                  end
               end
            end
            MUL: begin
               if (cnt == '0) pending <= product;
               else           cnt     <= cnt - 6'd1;
            end
            DIV: begin
               rem <= rem_nx;
               quo <= quo_nx;
               if (cnt == '0) pending <= {r_fix, q_fix};
               else           cnt     <= cnt - 6'd1;
            end
            DONE: begin
               if (!flush) begin
                  hi <= pending[63:32];
                  lo <= pending[31:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: vector table, random ops against a
// behavioural model, and hand sequences for flush and mid-operation reset.
module tb_muldiv_hilo_ctrl;

   localparam int unsigned MUL_CYCLES = 2;
   localparam int MUL_STALL = 1 + MUL_CYCLES;
   localparam int DIV_STALL = 33;

   logic        clk, rstn, op_valid, flush;
   logic [2:0]  op;
   logic [31:0] src_a, src_b;
   logic        arith_stall, busy, done;
   logic [31:0] hi, lo;

   muldiv_hilo_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk), .rstn(rstn), .op_valid(op_valid), .op(op),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .arith_stall(arith_stall), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, eh, el;
      int          stall;
   } vec_t;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   vec_t        vt[14];
   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] model_hi, model_lo;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb2;
      longint unsigned ua, ub;
      int              qa, qb;
      case (o)
         3'd0: begin sa = longint'($signed(a)); sb2 = longint'($signed(b)); return 64'(sa * sb2); end
         3'd1: begin ua = {32'd0, a}; ub = {32'd0, b}; return ua * ub; end
         3'd2: begin qa = $signed(a); qb = $signed(b); return {32'(qa % qb), 32'(qa / qb)}; end
         3'd3: return {a % b, a / b};
         default: return '0;
      endcase
   endfunction

   // Called between a negedge and the following posedge; returns at the same phase.
   task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall,
                         input logic [31:0] eh, input logic [31:0] el);
      int   st;
      exp_t e;
      op_valid = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0;
      sb.push_back('{eh, el});
      model_hi = eh; model_lo = el;
      #1;
      st = 0;
      while (arith_stall && st < 100) begin
         st++;
         @(negedge clk); #1;
      end
      chk({nm, " stall"}, 32'(st), 32'(exp_stall));
      chk({nm, " done"}, {31'd0, done}, (o <= 3'd3) ? 32'd1 : 32'd0);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      e = sb.pop_front();
      chk({nm, " hi"}, hi, e.hi);
      chk({nm, " lo"}, lo, e.lo);
      chk({nm, " busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      logic [63:0] rr;
      int          st;

      vt[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MUL_STALL};
      vt[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_STALL};
      vt[2]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       DIV_STALL};
      vt[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_STALL};
      vt[4]  = '{3'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, DIV_STALL};
      vt[5]  = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, DIV_STALL};
      vt[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_STALL};
      vt[7]  = '{3'd3, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, DIV_STALL};
      vt[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIV_STALL};
      vt[9]  = '{3'd4, 32'h0000CAFE, 32'd0,        32'h0000CAFE, 32'hFFFFFFFD, 0};
      vt[10] = '{3'd5, 32'h0000BEEF, 32'd0,        32'h0000CAFE, 32'h0000BEEF, 0};
      vt[11] = '{3'd6, 32'h11111111, 32'd9,        32'h0000CAFE, 32'h0000BEEF, 0};
      vt[12] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_STALL};
      vt[13] = '{3'd1, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, MUL_STALL};

      rstn = 1'b0; op_valid = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4; flush = 1'b0;
      model_hi = '0; model_lo = '0;
      #3;
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset stall", {31'd0, arith_stall}, 32'd0);
      @(negedge clk);
      rstn = 1'b1; op_valid = 1'b0;
      #1;

      // Back-to-back: each op is presented in the cycle right after the previous DONE.
      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].stall, vt[i].eh, vt[i].el);

      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 1000));
         if (rb == '0) rb = 32'd1;
         if (ro == 3'd2 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
         rr = ref_result(ro, ra, rb);
         run_op($sformatf("rnd%0d", i), ro, ra, rb, (ro <= 3'd1) ? MUL_STALL : DIV_STALL,
                rr[63:32], rr[31:0]);
      end

      // Flush on the 10th DIV cycle
      op_valid = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7; flush = 1'b0;
      #1 chk("div accept stall", {31'd0, arith_stall}, 32'd1);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush busy before", {31'd0, busy}, 32'd1);
      chk("flush stall held", {31'd0, arith_stall}, 32'd1);
      @(negedge clk);
      op_valid = 1'b0; flush = 1'b0;
      #1;
      chk("flush busy after", {31'd0, busy}, 32'd0);
      chk("flush stall after", {31'd0, arith_stall}, 32'd0);
      chk("flush hi kept", hi, model_hi);
      chk("flush lo kept", lo, model_lo);
      repeat (40) @(negedge clk);
      #1;
      chk("flush no done", {31'd0, done}, 32'd0);
      chk("flush hi later", hi, model_hi);
      chk("flush lo later", lo, model_lo);

      run_op("mthi", 3'd4, 32'h00001234, 32'd0, 0, 32'h00001234, model_lo);

      op_valid = 1'b1; op = 3'd5; src_a = 32'h55555555; flush = 1'b1;
      #1 chk("mtlo flush stall", {31'd0, arith_stall}, 32'd0);
      @(negedge clk); #1;
      chk("mtlo flush lo", lo, model_lo);
      op = 3'd0;
      #1 chk("mult flush stall", {31'd0, arith_stall}, 32'd0);
      @(negedge clk);
      op_valid = 1'b0; flush = 1'b0;
      #1 chk("mult flush busy", {31'd0, busy}, 32'd0);

      // Flush while in DONE discards the result
      op_valid = 1'b1; op = 3'd0; src_a = 32'd6; src_b = 32'd7; flush = 1'b0;
      #1;
      st = 0;
      while (arith_stall && st < 100) begin
         st++;
         @(negedge clk); #1;
      end
      chk("done flush stall", 32'(st), 32'(MUL_STALL));
      chk("done flush pulse", {31'd0, done}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      op_valid = 1'b0; flush = 1'b0;
      #1;
      chk("done flush hi", hi, model_hi);
      chk("done flush lo", lo, model_lo);
      chk("done flush done", {31'd0, done}, 32'd0);

      // Reset mid-MUL
      op_valid = 1'b1; op = 3'd1; src_a = 32'h00012345; src_b = 32'd7;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("rst mid hi", hi, 32'd0);
      chk("rst mid lo", lo, 32'd0);
      chk("rst mid busy", {31'd0, busy}, 32'd0);
      chk("rst mid stall", {31'd0, arith_stall}, 32'd0);
      @(negedge clk);
      rstn = 1'b1; op_valid = 1'b0;
      #1;
      chk("rst release busy", {31'd0, busy}, 32'd0);
      run_op("mult after rst", 3'd0, 32'd3, 32'd4, MUL_STALL, 32'd0, 32'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
